// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// A single full-adder slice computes a + ~b + 1 using a carry flop preset to 1.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last committed result
// RUN   | one operand bit processed per clock, LSB first
// DONE  | one-cycle done pulse with diff/borrow_out/overflow valid
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [CW-1:0]    cnt;
    logic             carry, c_msb_in;
    logic             s, c_out, nb, last;

    always_comb begin
        nb    = ~b_sh[0];
        s     = a_sh[0] ^ nb ^ carry;
        c_out = (a_sh[0] & nb) | (a_sh[0] & carry) | (nb & carry);
        last  = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            c_msb_in   <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    carry <= 1'b1;
                    cnt   <= '0;
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= {s, r_sh[WIDTH-1:1]};
                    carry <= c_out;
                    cnt   <= cnt + CW'(1);
                    // carry into the MSB, needed for the signed overflow test
                    if (cnt == PENULT) c_msb_in <= c_out;
                    if (last) begin
                        diff       <= {s, r_sh[WIDTH-1:1]};
                        borrow_out <= ~c_out;
                        overflow   <= c_msb_in ^ c_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
